// File: rtl/game_ctrl.sv
// Top-level game FSM: frame-sampled bird/pipe/ground collision, BCD score and high score.
// Optional HISCORE_EN: when defined, tracks the high score; otherwise high_score_bcd is tied to zero.
module game_ctrl #(
  parameter int BIRD_X       = 300,
  parameter int BIRD_SIZE    = 32,
  parameter int PIPE_W       = 80,
  parameter int PIPE_GAP_H   = 200,
  parameter int GROUND_Y     = 700,
  parameter int DEATH_FRAMES = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_en,
  input  logic        flap,
  input  logic [11:0] bird_y,
  input  logic [11:0] pipe1_x,
  input  logic [11:0] pipe1_gap_y,
  input  logic [11:0] pipe2_x,
  input  logic [11:0] pipe2_gap_y,
  input  logic        score_pulse,
  output logic [1:0]  state,
  output logic        game_active,
  output logic        collision,
  output logic [11:0] score_bcd,
  output logic [11:0] high_score_bcd
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PLAY  = 2'd1,
    S_DYING = 2'd2,
    S_OVER  = 2'd3
  } state_t;

  localparam int CNT_W = $clog2(DEATH_FRAMES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEATH_FRAMES - 1);
  localparam logic [12:0] BIRD_L    = 13'(BIRD_X);
  localparam logic [12:0] BIRD_R    = 13'(BIRD_X + BIRD_SIZE);
  localparam logic [12:0] BIRD_H    = 13'(BIRD_SIZE);
  localparam logic [12:0] PIPE_W13  = 13'(PIPE_W);
  localparam logic [12:0] GAP_HALF  = 13'(PIPE_GAP_H / 2);
  localparam logic [12:0] GROUND13  = 13'(GROUND_Y);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] death_cnt_q, death_cnt_d;
  logic             collision_q, collision_d;
  logic             game_active_q, game_active_d;
  logic [11:0]      score_q, score_d;
  logic             hit;

  // All terms widened to 13 bits so sums and the clamped gap bottom never wrap.
  function automatic logic pipe_hit(input logic [11:0] px, input logic [11:0] gy,
                                    input logic [11:0] by);
    logic [12:0] px13, gy13, by13, gap_lo;
    logic        x_ovl, in_gap;
    px13   = {1'b0, px};
    gy13   = {1'b0, gy};
    by13   = {1'b0, by};
    gap_lo = (gy13 < GAP_HALF) ? 13'd0 : gy13 - GAP_HALF;
    x_ovl  = (px13 < BIRD_R) && (px13 + PIPE_W13 > BIRD_L);
    in_gap = (by13 >= gap_lo) && (by13 + BIRD_H <= gy13 + GAP_HALF);
    return x_ovl && !in_gap;
  endfunction

  function automatic logic [11:0] bcd_inc(input logic [11:0] v);
    logic [3:0] d0, d1, d2;
    d2 = v[11:8];
    d1 = v[7:4];
    d0 = v[3:0];
    if (v == 12'h999) return v;
    if (d0 == 4'd9) begin
      d0 = 4'd0;
      if (d1 == 4'd9) begin
        d1 = 4'd0;
        d2 = d2 + 4'd1;
      end else begin
        d1 = d1 + 4'd1;
      end
    end else begin
      d0 = d0 + 4'd1;
    end
    return {d2, d1, d0};
  endfunction

  always_comb begin
    hit = pipe_hit(pipe1_x, pipe1_gap_y, bird_y)
        | pipe_hit(pipe2_x, pipe2_gap_y, bird_y)
        | (({1'b0, bird_y} + BIRD_H) >= GROUND13)
        | bird_y[11];
  end

  always_comb begin
    state_d     = state_q;
    death_cnt_d = death_cnt_q;
    collision_d = collision_q;
    score_d     = score_q;
    unique case (state_q)
      S_IDLE: begin
        if (flap) begin
          state_d     = S_PLAY;
          score_d     = 12'h000;
          collision_d = 1'b0;
        end
      end
      S_PLAY: begin
        // Score still counts on the edge that leaves PLAY.
        if (score_pulse) score_d = bcd_inc(score_q);
        if (frame_en && hit) begin
          state_d     = S_DYING;
          collision_d = 1'b1;
          death_cnt_d = '0;
        end
      end
      S_DYING: begin
        if (frame_en) begin
          death_cnt_d = death_cnt_q + 1'b1;
          if (death_cnt_q == CNT_LAST) state_d = S_OVER;
        end
      end
      S_OVER: begin
        if (flap) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    game_active_d = (state_d == S_PLAY);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      death_cnt_q   <= '0;
      collision_q   <= 1'b0;
      game_active_q <= 1'b0;
      score_q       <= 12'h000;
    end else begin
      state_q       <= state_d;
      death_cnt_q   <= death_cnt_d;
      collision_q   <= collision_d;
      game_active_q <= game_active_d;
      score_q       <= score_d;
    end
  end

`ifdef HISCORE_EN
  logic [11:0] high_q, high_d;

  // Plain binary compare orders packed BCD correctly.
  always_comb begin
    high_d = high_q;
    if (state_q == S_DYING && state_d == S_OVER && score_q > high_q) high_d = score_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) high_q <= 12'h000;
    else     high_q <= high_d;
  end

  assign high_score_bcd = high_q;
`else
  assign high_score_bcd = 12'h000;
`endif

  assign state       = state_q;
  assign game_active = game_active_q;
  assign collision   = collision_q;
  assign score_bcd   = score_q;

endmodule
